config_reg_bank: RTL

//   Slave end of the config bus: sinks write_config_i writes into a bank of NUM_REGS

---
 rtl/config_reg_bank_pkg.sv | 41 ++++
 rtl/config_reg_bank_if.sv | 24 ++
 rtl/config_addr_decode.sv | 23 ++
 rtl/config_reg_bank.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/config_reg_bank_pkg.sv
// Shared types and the address-decode helper for the config register bank.
package config_reg_bank_pkg;

  localparam int unsigned AXIL_DATA_BITS = 64;
  localparam int unsigned AXIL_ADDR_BITS = 32;
  localparam int unsigned CFG_STRIDE     = AXIL_DATA_BITS / 8;
  localparam int unsigned CFG_IDX_W      = 16;

  typedef struct packed {
    logic [AXIL_DATA_BITS-1:0] data;
    logic                      error;
  } cfg_resp_t;

  typedef struct packed {
    logic                 hit;
    logic [CFG_IDX_W-1:0] idx;
  } cfg_dec_t;

  typedef enum logic {
    RESP_IDLE = 1'b0,
    RESP_FULL = 1'b1
  } resp_state_t;

  // Maps a byte address onto a slot index; misaligned, below-base and past-end are misses.
  function automatic cfg_dec_t cfg_addr_decode(
    input logic [AXIL_ADDR_BITS-1:0] addr,
    input logic [AXIL_ADDR_BITS-1:0] base,
    input logic [AXIL_ADDR_BITS-1:0] stride,
    input logic [AXIL_ADDR_BITS-1:0] n
  );
    cfg_dec_t                  res;
    logic [AXIL_ADDR_BITS-1:0] off;
    logic [AXIL_ADDR_BITS-1:0] slot;
    off      = addr - base;
    slot     = off / stride;
    res.hit  = (addr >= base) && ((off % stride) == '0) && (slot < n);
    res.idx  = CFG_IDX_W'(slot);
    return res;
  endfunction

endpackage

// File: rtl/config_reg_bank_if.sv
// Config bus interfaces: fire-and-forget write channel and request/response read channel.
interface write_config_i;
  import config_reg_bank_pkg::*;
  logic [AXIL_ADDR_BITS-1:0] addr;
  logic [AXIL_DATA_BITS-1:0] data;
  logic                      valid;

  modport m (output addr, data, valid);
  modport s (input  addr, data, valid);
endinterface

interface read_config_i;
  import config_reg_bank_pkg::*;
  logic [AXIL_ADDR_BITS-1:0] addr;
  logic                      valid;
  logic                      ready;
  logic [AXIL_DATA_BITS-1:0] resp_data;
  logic                      resp_error;
  logic                      resp_valid;
  logic                      resp_ready;

  modport m (output addr, valid, resp_ready, input  ready, resp_data, resp_error, resp_valid);
  modport s (input  addr, valid, resp_ready, output ready, resp_data, resp_error, resp_valid);
endinterface

// File: rtl/config_addr_decode.sv
// Combinational address decoder; one copy each for the write and read paths.
module config_addr_decode
  import config_reg_bank_pkg::*;
#(
  parameter logic [AXIL_ADDR_BITS-1:0] BASE_ADDR   = '0,
  parameter int unsigned               NUM_ENTRIES = 16,
  parameter int unsigned               IDX_BITS    = 5
) (
  input  logic [AXIL_ADDR_BITS-1:0] addr_i,
  output logic                      hit_o,
  output logic [IDX_BITS-1:0]       idx_o
);

  cfg_dec_t dec;

  always_comb begin
    dec   = cfg_addr_decode(addr_i, BASE_ADDR, AXIL_ADDR_BITS'(CFG_STRIDE),
                            AXIL_ADDR_BITS'(NUM_ENTRIES));
    hit_o = dec.hit;
    idx_o = IDX_BITS'(dec.idx);
  end

endmodule

// File: rtl/config_reg_bank.sv
// Config register bank: write sink, single-entry read response register.
// Optional CONFIG_BANK_WRITE_COUNT_EN adds a read-only accepted-write counter after the last register.
//
// state     | meaning
// RESP_IDLE | no response held, read request always accepted
// RESP_FULL | response held on resp_*, new read accepted only with resp_ready
module config_reg_bank
  import config_reg_bank_pkg::*;
#(
  parameter int unsigned               NUM_REGS    = 16,
  parameter logic [AXIL_ADDR_BITS-1:0] BASE_ADDR   = '0,
  parameter logic [AXIL_DATA_BITS-1:0] RESET_VALUE = '0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  write_config_i.s                                write_config,
  read_config_i.s                                 read_config,
  output logic [NUM_REGS-1:0][AXIL_DATA_BITS-1:0] regs_o,
  output logic [NUM_REGS-1:0]                     reg_update_o,
  output logic                                    write_error_o
);

  localparam int unsigned IDX_BITS = ($clog2(NUM_REGS + 1) > 1) ? $clog2(NUM_REGS + 1) : 1;
`ifdef CONFIG_BANK_WRITE_COUNT_EN
  localparam int unsigned NUM_DEC = NUM_REGS + 1;
`else
  localparam int unsigned NUM_DEC = NUM_REGS;
`endif

  logic [NUM_REGS-1:0][AXIL_DATA_BITS-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                     reg_update_q, reg_update_d;
  logic                                    write_error_q, write_error_d;
  resp_state_t                             resp_state_q, resp_state_d;
  cfg_resp_t                               resp_q, resp_d;

  logic                      w_hit, r_hit;
  logic [IDX_BITS-1:0]       w_idx, r_idx;
  logic [AXIL_DATA_BITS-1:0] r_data;
  logic                      read_ready;
  logic                      read_accept;

  config_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .NUM_ENTRIES(NUM_DEC),
    .IDX_BITS   (IDX_BITS)
  ) u_wr_decode (
    .addr_i(write_config.addr),
    .hit_o (w_hit),
    .idx_o (w_idx)
  );

  config_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .NUM_ENTRIES(NUM_DEC),
    .IDX_BITS   (IDX_BITS)
  ) u_rd_decode (
    .addr_i(read_config.addr),
    .hit_o (r_hit),
    .idx_o (r_idx)
  );

  // Only real registers take writes; the counter slot falls through to an error.
  always_comb begin
    regs_d       = regs_q;
    reg_update_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (write_config.valid && w_hit && (w_idx == IDX_BITS'(i))) begin
        regs_d[i]       = write_config.data;
        reg_update_d[i] = 1'b1;
      end
    end
    write_error_d = write_config.valid && !(|reg_update_d);
  end

`ifdef CONFIG_BANK_WRITE_COUNT_EN
  logic [AXIL_DATA_BITS-1:0] write_count_q, write_count_d;

  always_comb begin
    write_count_d = write_count_q + AXIL_DATA_BITS'(|reg_update_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_count_q <= '0;
    end else begin
      write_count_q <= write_count_d;
    end
  end
`endif

  // Read mux samples regs_q, so a same-cycle write is not yet visible.
  always_comb begin
    r_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_idx == IDX_BITS'(i)) begin
        r_data = regs_q[i];
      end
    end
`ifdef CONFIG_BANK_WRITE_COUNT_EN
    if (r_idx == IDX_BITS'(NUM_REGS)) begin
      r_data = write_count_q;
    end
`endif
  end

  assign read_ready  = (resp_state_q == RESP_IDLE) || read_config.resp_ready;
  assign read_accept = read_config.valid && read_ready;

  always_comb begin
    resp_state_d = resp_state_q;
    resp_d       = resp_q;
    if (read_accept) begin
      resp_state_d = RESP_FULL;
      resp_d.data  = r_hit ? r_data : '0;
      resp_d.error = !r_hit;
    end else if (read_config.resp_ready) begin
      resp_state_d = RESP_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q        <= {NUM_REGS{RESET_VALUE}};
      reg_update_q  <= '0;
      write_error_q <= 1'b0;
      resp_state_q  <= RESP_IDLE;
      resp_q        <= '0;
    end else begin
      regs_q        <= regs_d;
      reg_update_q  <= reg_update_d;
      write_error_q <= write_error_d;
      resp_state_q  <= resp_state_d;
      resp_q        <= resp_d;
    end
  end

  assign regs_o                 = regs_q;
  assign reg_update_o           = reg_update_q;
  assign write_error_o          = write_error_q;
  assign read_config.ready      = read_ready;
  assign read_config.resp_valid = (resp_state_q == RESP_FULL);
  assign read_config.resp_data  = resp_q.data;
  assign read_config.resp_error = resp_q.error;

endmodule
